// File: rtl/exec_core.sv
// exec_core: single-cycle 8-bit execution core.
// It has four 8-bit registers (R3 is the stack pointer) and an 8-bit data memory.
// An instruction presented with instr_valid retires on the next rising edge.
module exec_core #(
  parameter int unsigned MEM_DEPTH = 256,
  parameter logic [7:0]  SP_INIT   = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       instr_valid,
  input  logic [7:0] instruction,
  input  logic [7:0] pc,
  output logic [7:0] next_pc,
  output logic       done,
  output logic       overflow,
  output logic       halted,
  input  logic [1:0] dbg_addr,
  output logic [7:0] dbg_data
);

  localparam int unsigned AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_SLT  = 4'h5,
    OP_ADDI = 4'h6,
    OP_SLL  = 4'h7,
    OP_J    = 4'h8,
    OP_JAL  = 4'h9,
    OP_LW   = 4'hA,
    OP_SW   = 4'hB,
    OP_BEQ  = 4'hC,
    OP_BNE  = 4'hD,
    OP_RET  = 4'hE,
    OP_HALT = 4'hF
  } opcode_t;

  logic [7:0] regs [4];
  logic [7:0] mem  [MEM_DEPTH];

  // Byte addresses wrap onto the memory depth.
  function automatic logic [AW-1:0] mem_idx(input logic [7:0] addr);
    return AW'({24'd0, addr} % MEM_DEPTH);
  endfunction

  opcode_t    op;
  logic [1:0] ra, rb;
  logic [7:0] a, b, imm4, imm2, pc_inc, sp, sp_dec, sp_inc;
  logic       exec;

  assign op       = opcode_t'(instruction[7:4]);
  assign ra       = instruction[3:2];
  assign rb       = instruction[1:0];
  assign a        = regs[ra];
  assign b        = regs[rb];
  assign imm4     = {{4{instruction[3]}}, instruction[3:0]};
  assign imm2     = {{6{instruction[1]}}, instruction[1:0]};
  assign pc_inc   = pc + 8'd1;
  assign sp       = regs[3];
  assign sp_dec   = sp - 8'd1;
  assign sp_inc   = sp + 8'd1;
  assign exec     = instr_valid && !halted;
  assign dbg_data = regs[dbg_addr];

  logic       rf_we, mem_we, ov, halt_set;
  logic [1:0] rf_waddr;
  logic [7:0] rf_wdata, mem_waddr, mem_wdata, npc, sum, diff, isum;

  // Decode and execute: produce the write-back, memory write, next PC and overflow.
  always_comb begin
    rf_we     = 1'b0;
    rf_waddr  = ra;
    rf_wdata  = '0;
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    npc       = pc_inc;
    ov        = 1'b0;
    halt_set  = 1'b0;
    sum       = a + b;
    diff      = a - b;
    isum      = a + imm2;
    case (op)
      OP_NOP: ;
      OP_ADD: begin
        rf_we    = 1'b1;
        rf_wdata = sum;
        ov       = (a[7] == b[7]) && (sum[7] != a[7]);
      end
      OP_SUB: begin
        rf_we    = 1'b1;
        rf_wdata = diff;
        ov       = (a[7] != b[7]) && (diff[7] != a[7]);
      end
      OP_AND: begin
        rf_we    = 1'b1;
        rf_wdata = a & b;
      end
      OP_OR: begin
        rf_we    = 1'b1;
        rf_wdata = a | b;
      end
      OP_SLT: begin
        rf_we    = 1'b1;
        rf_wdata = ($signed(a) < $signed(b)) ? 8'd1 : 8'd0;
      end
      OP_ADDI: begin
        rf_we    = 1'b1;
        rf_wdata = isum;
        ov       = (a[7] == imm2[7]) && (isum[7] != a[7]);
      end
      OP_SLL: begin
        rf_we    = 1'b1;
        rf_wdata = a << b[2:0];
      end
      OP_J: npc = pc_inc + imm4;
      OP_JAL: begin
        mem_we    = 1'b1;
        mem_waddr = sp;
        mem_wdata = pc_inc;
        rf_we     = 1'b1;
        rf_waddr  = 2'd3;
        rf_wdata  = sp_dec;
        npc       = pc_inc + imm4;
      end
      OP_LW: begin
        rf_we    = 1'b1;
        rf_wdata = mem[mem_idx(b)];
      end
      OP_SW: begin
        mem_we    = 1'b1;
        mem_waddr = b;
        mem_wdata = a;
      end
      OP_BEQ: if (a == b) npc = pc_inc + regs[0];
      OP_BNE: if (a != b) npc = pc_inc + regs[0];
      OP_RET: begin
        rf_we    = 1'b1;
        rf_waddr = 2'd3;
        rf_wdata = sp_inc;
        npc      = mem[mem_idx(sp_inc)];
      end
      OP_HALT: halt_set = 1'b1;
      default: ;
    endcase
  end

  // Architectural state: register file, PC result, status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      regs[0]  <= '0;
      regs[1]  <= '0;
      regs[2]  <= '0;
      regs[3]  <= SP_INIT;
      next_pc  <= '0;
      done     <= 1'b0;
      overflow <= 1'b0;
      halted   <= 1'b0;
    end else if (exec) begin
      if (rf_we) regs[rf_waddr] <= rf_wdata;
      next_pc  <= npc;
      done     <= 1'b1;
      overflow <= ov;
      if (halt_set) halted <= 1'b1;
    end else begin
      done <= 1'b0;
    end
  end

  // Data memory write port; reset discards the instruction but leaves contents intact.
  always_ff @(posedge clk) begin
    if (!rst && exec && mem_we) mem[mem_idx(mem_waddr)] <= mem_wdata;
  end

endmodule

// File: tb/tb_exec_core.sv
// tb_exec_core: directed vector table plus hand sequences for reset, halt and idle behaviour.
module tb_exec_core;

  logic       clk = 1'b0;
  logic       rst, instr_valid;
  logic [7:0] instruction, pc, next_pc, dbg_data;
  logic       done, overflow, halted;
  logic [1:0] dbg_addr;

  int checks = 0;
  int errors = 0;

  exec_core #(.MEM_DEPTH(256), .SP_INIT(8'hFF)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instruction(instruction),
    .pc(pc), .next_pc(next_pc), .done(done), .overflow(overflow),
    .halted(halted), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] instr;
    logic [7:0] pc;
    logic [1:0] rsel;
    logic [7:0] rexp;
    logic [7:0] npc;
    logic       ov;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [7:0] i, input logic [7:0] p, input logic [1:0] r,
                              input logic [7:0] re, input logic [7:0] n, input logic o);
    vec_t v;
    v.instr = i; v.pc = p; v.rsel = r; v.rexp = re; v.npc = n; v.ov = o;
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [7:0] ins, input logic [7:0] p, input logic v);
    @(negedge clk);
    instruction = ins;
    pc          = p;
    instr_valid = v;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
  endtask

  task automatic check_reg(input string name, input logic [1:0] r, input logic [7:0] exp);
    dbg_addr = r;
    #1;
    check(name, dbg_data, exp);
  endtask

  initial begin
    // instr, pc, reg, reg value, next_pc, overflow
    vecs.push_back(mk(8'hBC, 8'h00, 2'd3, 8'hFF, 8'h01, 1'b0)); // sw R3->M[R0]
    vecs.push_back(mk(8'h67, 8'h01, 2'd1, 8'hFF, 8'h02, 1'b0)); // addi R1,-1
    vecs.push_back(mk(8'h61, 8'h02, 2'd0, 8'h01, 8'h03, 1'b0)); // addi R0,+1
    vecs.push_back(mk(8'h71, 8'h03, 2'd0, 8'h80, 8'h04, 1'b0)); // sll R0,R1 (by 7)
    vecs.push_back(mk(8'h63, 8'h04, 2'd0, 8'h7F, 8'h05, 1'b1)); // addi R0,-1 overflow
    vecs.push_back(mk(8'h10, 8'h05, 2'd0, 8'hFE, 8'h06, 1'b1)); // add R0,R0 overflow
    vecs.push_back(mk(8'h00, 8'h06, 2'd0, 8'hFE, 8'h07, 1'b0)); // nop clears ov
    vecs.push_back(mk(8'h56, 8'h07, 2'd1, 8'h01, 8'h08, 1'b0)); // slt R1,R2 -1<0
    vecs.push_back(mk(8'h58, 8'h08, 2'd2, 8'h00, 8'h09, 1'b0)); // slt R2,R0 0<-2 no
    vecs.push_back(mk(8'h48, 8'h09, 2'd2, 8'hFE, 8'h0A, 1'b0)); // or R2,R0
    vecs.push_back(mk(8'h39, 8'h0A, 2'd2, 8'h00, 8'h0B, 1'b0)); // and R2,R1
    vecs.push_back(mk(8'h69, 8'h0B, 2'd2, 8'h01, 8'h0C, 1'b0)); // addi R2,+1
    vecs.push_back(mk(8'h7B, 8'h0C, 2'd2, 8'h80, 8'h0D, 1'b0)); // sll R2,R3 (by 7)
    vecs.push_back(mk(8'h29, 8'h0D, 2'd2, 8'h7F, 8'h0E, 1'b1)); // sub R2,R1 overflow
    vecs.push_back(mk(8'h2A, 8'h0E, 2'd2, 8'h00, 8'h0F, 1'b0)); // sub R2,R2
    vecs.push_back(mk(8'h15, 8'h0F, 2'd1, 8'h02, 8'h10, 1'b0)); // add R1,R1
    vecs.push_back(mk(8'h15, 8'h10, 2'd1, 8'h04, 8'h11, 1'b0));
    vecs.push_back(mk(8'h65, 8'h11, 2'd1, 8'h05, 8'h12, 1'b0)); // addi R1,+1
    vecs.push_back(mk(8'h69, 8'h12, 2'd2, 8'h01, 8'h13, 1'b0));
    vecs.push_back(mk(8'h79, 8'h13, 2'd2, 8'h20, 8'h14, 1'b0)); // sll R2,R1 (by 5)
    vecs.push_back(mk(8'h15, 8'h14, 2'd1, 8'h0A, 8'h15, 1'b0));
    vecs.push_back(mk(8'h65, 8'h15, 2'd1, 8'h0B, 8'h16, 1'b0));
    vecs.push_back(mk(8'h15, 8'h16, 2'd1, 8'h16, 8'h17, 1'b0));
    vecs.push_back(mk(8'h15, 8'h17, 2'd1, 8'h2C, 8'h18, 1'b0));
    vecs.push_back(mk(8'h65, 8'h18, 2'd1, 8'h2D, 8'h19, 1'b0));
    vecs.push_back(mk(8'h15, 8'h19, 2'd1, 8'h5A, 8'h1A, 1'b0));
    vecs.push_back(mk(8'hB6, 8'h1A, 2'd1, 8'h5A, 8'h1B, 1'b0)); // sw R1->M[R2]
    vecs.push_back(mk(8'hA2, 8'h1B, 2'd0, 8'h5A, 8'h1C, 1'b0)); // lw R0<=M[R2]
    vecs.push_back(mk(8'h20, 8'h1C, 2'd0, 8'h00, 8'h1D, 1'b0)); // sub R0,R0
    vecs.push_back(mk(8'h61, 8'h1D, 2'd0, 8'h01, 8'h1E, 1'b0));
    vecs.push_back(mk(8'h10, 8'h1E, 2'd0, 8'h02, 8'h1F, 1'b0));
    vecs.push_back(mk(8'h10, 8'h1F, 2'd0, 8'h04, 8'h20, 1'b0));
    vecs.push_back(mk(8'h61, 8'h20, 2'd0, 8'h05, 8'h21, 1'b0));
    vecs.push_back(mk(8'hC5, 8'h08, 2'd0, 8'h05, 8'h0E, 1'b0)); // beq R1,R1 taken
    vecs.push_back(mk(8'hD5, 8'h08, 2'd0, 8'h05, 8'h09, 1'b0)); // bne R1,R1 not taken
    vecs.push_back(mk(8'hC6, 8'h30, 2'd2, 8'h20, 8'h31, 1'b0)); // beq R1,R2 not taken
    vecs.push_back(mk(8'hD6, 8'h30, 2'd2, 8'h20, 8'h36, 1'b0)); // bne R1,R2 taken
    vecs.push_back(mk(8'h88, 8'h05, 2'd3, 8'hFF, 8'hFE, 1'b0)); // j -8 wraps down
    vecs.push_back(mk(8'h87, 8'hF9, 2'd3, 8'hFF, 8'h01, 1'b0)); // j +7 wraps up
    vecs.push_back(mk(8'h93, 8'h10, 2'd3, 8'hFE, 8'h14, 1'b0)); // jal +3
    vecs.push_back(mk(8'hE0, 8'h14, 2'd3, 8'hFF, 8'h11, 1'b0)); // ret
    vecs.push_back(mk(8'hA3, 8'h15, 2'd0, 8'h11, 8'h16, 1'b0)); // lw R0<=M[R3] return addr
    vecs.push_back(mk(8'hE0, 8'h22, 2'd3, 8'h00, 8'hFF, 1'b0)); // ret, SP wraps FF->00
    vecs.push_back(mk(8'h90, 8'h40, 2'd3, 8'hFF, 8'h41, 1'b0)); // jal +0, SP wraps 00->FF
    vecs.push_back(mk(8'hE0, 8'h50, 2'd3, 8'h00, 8'h41, 1'b0)); // ret reads M[00]
    vecs.push_back(mk(8'h9F, 8'h60, 2'd3, 8'hFF, 8'h60, 1'b0)); // jal -1
    vecs.push_back(mk(8'h6E, 8'h61, 2'd3, 8'hFD, 8'h62, 1'b0)); // addi R3,-2
    vecs.push_back(mk(8'h6D, 8'h62, 2'd3, 8'hFE, 8'h63, 1'b0)); // addi R3,+1
    vecs.push_back(mk(8'h6D, 8'h63, 2'd3, 8'hFF, 8'h64, 1'b0));

    rst = 1'b1; instr_valid = 1'b0; instruction = '0; pc = '0; dbg_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    check_reg("rst_r0", 2'd0, 8'h00);
    check_reg("rst_r1", 2'd1, 8'h00);
    check_reg("rst_r2", 2'd2, 8'h00);
    check_reg("rst_r3", 2'd3, 8'hFF);
    check("rst_done", {7'd0, done}, 8'h00);
    check("rst_npc", next_pc, 8'h00);
    check("rst_ov", {7'd0, overflow}, 8'h00);
    check("rst_halted", {7'd0, halted}, 8'h00);

    foreach (vecs[i]) begin
      issue(vecs[i].instr, vecs[i].pc, 1'b1);
      check($sformatf("v%0d_done", i), {7'd0, done}, 8'h01);
      check($sformatf("v%0d_npc", i), next_pc, vecs[i].npc);
      check($sformatf("v%0d_ov", i), {7'd0, overflow}, {7'd0, vecs[i].ov});
      check_reg($sformatf("v%0d_reg", i), vecs[i].rsel, vecs[i].rexp);
    end

    // Idle cycle: nothing executes, state holds
    issue(8'h10, 8'h99, 1'b0);
    check("idle_done", {7'd0, done}, 8'h00);
    check("idle_npc", next_pc, 8'h64);
    check_reg("idle_r0", 2'd0, 8'h11);

    // Halt, then a valid add is ignored
    issue(8'hF0, 8'h70, 1'b1);
    check("halt_done", {7'd0, done}, 8'h01);
    check("halt_flag", {7'd0, halted}, 8'h01);
    check("halt_npc", next_pc, 8'h71);
    issue(8'h10, 8'h80, 1'b1);
    check("halted_done", {7'd0, done}, 8'h00);
    check("halted_flag", {7'd0, halted}, 8'h01);
    check("halted_npc", next_pc, 8'h71);
    check_reg("halted_r0", 2'd0, 8'h11);
    check_reg("halted_r1", 2'd1, 8'h5A);
    check_reg("halted_r2", 2'd2, 8'h20);
    check_reg("halted_r3", 2'd3, 8'hFF);

    // Reset wins over a simultaneous instruction and clears halted
    @(negedge clk);
    rst = 1'b1; instr_valid = 1'b1; instruction = 8'h10; pc = 8'h90;
    @(posedge clk);
    #1;
    rst = 1'b0; instr_valid = 1'b0;
    check("rst2_halted", {7'd0, halted}, 8'h00);
    check("rst2_done", {7'd0, done}, 8'h00);
    check("rst2_npc", next_pc, 8'h00);
    check_reg("rst2_r0", 2'd0, 8'h00);
    check_reg("rst2_r3", 2'd3, 8'hFF);

    // Memory survives reset
    issue(8'hA3, 8'h00, 1'b1);
    check("mem_keep_done", {7'd0, done}, 8'h01);
    check("mem_keep_npc", next_pc, 8'h01);
    check_reg("mem_keep_r0", 2'd0, 8'h11);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
